// File: rtl/pipe_mem_ls.sv
// -----------------------------------------------------------------------------
// pipe_mem_ls -- MEM pipeline stage between EXE and WB.
//
// Holds one instruction in a stage register. Loads and stores talk to data
// memory over a request/response port whose latency can vary. Byte and half
// accesses are supported, with signed or unsigned loads. Misaligned accesses
// raise an address exception when the instruction is captured. The result for
// WB comes from the ALU, the load data, HI or LO. A pending flag tells EXE
// stall logic that a load result is not available yet.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             kill the instruction in this stage (exception/eret in WB)
//   ex_wb             WB takes an exception this cycle; no new request issues
//   exe_mem_validto   EXE presents a valid instruction
//   mem_allowin       this stage can accept an instruction this cycle
//   wb_allowin        WB can accept an instruction this cycle
//   mem_wb_validto    valid instruction presented to WB
//   *_in              instruction fields captured from EXE
//   dreq_*            data-memory request channel (valid/ready handshake)
//   drsp_*            data-memory response channel (one response per request)
//   pc .. badvaddr    instruction fields presented to WB
//   fwd_valid         rdc_mem/wb_result can be forwarded to EXE
//   fwd_pending       load in the stage whose data has not returned yet
// -----------------------------------------------------------------------------
module pipe_mem_ls #(
  parameter int         PADDR_W  = 32,
  parameter int         RDC_W    = 5,
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               ex_wb,
  input  logic               exe_mem_validto,
  output logic               mem_allowin,
  input  logic               wb_allowin,
  output logic               mem_wb_validto,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        rt_in,
  input  logic [31:0]        hi_in,
  input  logic [31:0]        lo_in,
  input  logic               ld_in,
  input  logic               st_in,
  input  logic [1:0]         size_in,
  input  logic               sext_in,
  input  logic [1:0]         rd_mux_sel_in,
  input  logic               rf_we_in,
  input  logic [RDC_W-1:0]   rdc_in,
  input  logic               ex_in,
  input  logic [4:0]         ex_code_in,
  output logic               dreq_valid,
  input  logic               dreq_ready,
  output logic               dreq_we,
  output logic [3:0]         dreq_wstrb,
  output logic [PADDR_W-1:0] dreq_addr,
  output logic [31:0]        dreq_wdata,
  input  logic               drsp_valid,
  input  logic [31:0]        drsp_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        wb_result,
  output logic [RDC_W-1:0]   rdc_mem,
  output logic               rf_we,
  output logic               ex,
  output logic [4:0]         ex_code,
  output logic [31:0]        badvaddr,
  output logic               fwd_valid,
  output logic               fwd_pending
);

  typedef enum logic [1:0] {
    S_IDLE,    // no request outstanding
    S_WAIT,    // request accepted, waiting for the response
    S_DONE,    // response latched, result ready for WB
    S_CANCEL   // instruction flushed while waiting; drain the response
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_HI   = 2'd2;

  state_t state, state_next;

  logic             mem_valid;
  logic             ready_go;
  logic             need_access;
  logic             capture;
  logic             misalign;

  logic [31:0]      pc_r, alu_r, rt_r, hi_r, lo_r, rdata_r, badvaddr_r;
  logic             ld_r, st_r, sext_r, rf_we_r, ex_r;
  logic [1:0]       size_r, sel_r;
  logic [RDC_W-1:0] rdc_r;
  logic [4:0]       ex_code_r;

  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_data;

  // An excepting instruction never touches memory, and a flush or a WB
  // exception must stop a request from being issued in the same cycle.
  assign need_access = mem_valid && (ld_r || st_r) && !ex_r && !flush && !ex_wb;

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (flush)
        mem_valid <= 1'b0;
      else if (mem_allowin)
        mem_valid <= exe_mem_validto;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    dreq_valid = 1'b0;
    ready_go   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (need_access) begin
          dreq_valid = 1'b1;
          if (dreq_ready)
            state_next = S_WAIT;
        end else begin
          ready_go = 1'b1;
        end
      end
      S_WAIT: begin
        // A response arriving together with the flush is simply dropped.
        if (flush)
          state_next = drsp_valid ? S_IDLE : S_CANCEL;
        else if (drsp_valid)
          state_next = S_DONE;
      end
      S_DONE: begin
        ready_go = 1'b1;
        if (flush || wb_allowin)
          state_next = S_IDLE;
      end
      S_CANCEL: begin
        if (drsp_valid)
          state_next = S_IDLE;
      end
    endcase
  end

  // The stage stays closed while a cancelled request is still outstanding,
  // so its response can never be mistaken for a newer request's data.
  assign mem_allowin    = (state != S_CANCEL) && (!mem_valid || (ready_go && wb_allowin));
  assign mem_wb_validto = mem_valid && ready_go && !flush;

  // ---------------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------------
  assign capture  = exe_mem_validto && mem_allowin;
  assign misalign = (ld_in || st_in) &&
                    (((size_in == SZ_HALF) && alu_result_in[0]) ||
                     ((size_in == SZ_WORD) && (alu_result_in[1:0] != 2'b00)));

  // NOTE: the data fields are reset as well; they drive WB outputs directly,
  // and a known value after reset keeps those outputs quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= '0;
      alu_r      <= '0;
      rt_r       <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      ld_r       <= 1'b0;
      st_r       <= 1'b0;
      size_r     <= '0;
      sext_r     <= 1'b0;
      sel_r      <= '0;
      rf_we_r    <= 1'b0;
      rdc_r      <= '0;
      ex_r       <= 1'b0;
      ex_code_r  <= '0;
      badvaddr_r <= '0;
      rdata_r    <= '0;
    end else begin
      if (capture) begin
        pc_r       <= pc_in;
        alu_r      <= alu_result_in;
        rt_r       <= rt_in;
        hi_r       <= hi_in;
        lo_r       <= lo_in;
        ld_r       <= ld_in;
        st_r       <= st_in;
        size_r     <= size_in;
        sext_r     <= sext_in;
        sel_r      <= rd_mux_sel_in;
        rdc_r      <= rdc_in;
        ex_r       <= ex_in || misalign;
        rf_we_r    <= rf_we_in && !ex_in && !misalign;
        // An upstream exception is older than the alignment check and wins.
        if (ex_in)
          ex_code_r <= ex_code_in;
        else if (misalign)
          ex_code_r <= ld_in ? EXC_ADEL : EXC_ADES;
        else
          ex_code_r <= ex_code_in;
        badvaddr_r <= (ex_in || misalign) ? alu_result_in : 32'd0;
      end
      if (state == S_WAIT && drsp_valid && !flush)
        rdata_r <= drsp_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Request channel: word-aligned address, store data replicated across lanes
  // ---------------------------------------------------------------------------
  assign dreq_addr = {alu_r[PADDR_W-1:2], 2'b00};
  assign dreq_we   = st_r;

  always_comb begin
    dreq_wstrb = 4'b0000;
    dreq_wdata = rt_r;
    if (st_r) begin
      unique case (size_r)
        SZ_BYTE: begin
          dreq_wstrb = 4'b0001 << alu_r[1:0];
          dreq_wdata = {4{rt_r[7:0]}};
        end
        SZ_HALF: begin
          dreq_wstrb = alu_r[1] ? 4'b1100 : 4'b0011;
          dreq_wdata = {2{rt_r[15:0]}};
        end
        default: begin
          dreq_wstrb = 4'b1111;
          dreq_wdata = rt_r;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction and WB result
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (alu_r[1:0])
      2'd0:    load_byte = rdata_r[7:0];
      2'd1:    load_byte = rdata_r[15:8];
      2'd2:    load_byte = rdata_r[23:16];
      default: load_byte = rdata_r[31:24];
    endcase
    load_half = alu_r[1] ? rdata_r[31:16] : rdata_r[15:0];
    unique case (size_r)
      SZ_BYTE: load_data = {{24{sext_r & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{sext_r & load_half[15]}}, load_half};
      default: load_data = rdata_r;
    endcase
  end

  always_comb begin
    unique case (sel_r)
      SEL_ALU:  wb_result = alu_r;
      SEL_LOAD: wb_result = load_data;
      SEL_HI:   wb_result = hi_r;
      default:  wb_result = lo_r;
    endcase
  end

  assign pc       = pc_r;
  assign rdc_mem  = rdc_r;
  assign rf_we    = rf_we_r;
  assign ex       = ex_r;
  assign ex_code  = ex_code_r;
  assign badvaddr = badvaddr_r;

  // A load result is only forwardable once its data has been latched.
  assign fwd_valid   = mem_valid && rf_we_r && (!ld_r || state == S_DONE);
  assign fwd_pending = mem_valid && ld_r && rf_we_r && (state != S_DONE);

endmodule

// File: tb/tb_pipe_mem_ls.sv
// -----------------------------------------------------------------------------
// tb_pipe_mem_ls -- directed self-checking bench for pipe_mem_ls.
// Inputs change on the falling clock edge and outputs are sampled shortly
// after, so the DUT captures on the rising edge with stable inputs. Expected
// WB transfers are queued when an instruction is driven and compared when the
// DUT hands an instruction to WB.
// -----------------------------------------------------------------------------
module tb_pipe_mem_ls;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_wb;
  logic        exe_mem_validto;
  logic        mem_allowin;
  logic        wb_allowin;
  logic        mem_wb_validto;
  logic [31:0] pc_in, alu_result_in, rt_in, hi_in, lo_in;
  logic        ld_in, st_in;
  logic [1:0]  size_in;
  logic        sext_in;
  logic [1:0]  rd_mux_sel_in;
  logic        rf_we_in;
  logic [4:0]  rdc_in;
  logic        ex_in;
  logic [4:0]  ex_code_in;
  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_we;
  logic [3:0]  dreq_wstrb;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;
  logic [31:0] pc, wb_result;
  logic [4:0]  rdc_mem;
  logic        rf_we;
  logic        ex;
  logic [4:0]  ex_code;
  logic [31:0] badvaddr;
  logic        fwd_valid;
  logic        fwd_pending;

  pipe_mem_ls dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .ex_wb           (ex_wb),
    .exe_mem_validto (exe_mem_validto),
    .mem_allowin     (mem_allowin),
    .wb_allowin      (wb_allowin),
    .mem_wb_validto  (mem_wb_validto),
    .pc_in           (pc_in),
    .alu_result_in   (alu_result_in),
    .rt_in           (rt_in),
    .hi_in           (hi_in),
    .lo_in           (lo_in),
    .ld_in           (ld_in),
    .st_in           (st_in),
    .size_in         (size_in),
    .sext_in         (sext_in),
    .rd_mux_sel_in   (rd_mux_sel_in),
    .rf_we_in        (rf_we_in),
    .rdc_in          (rdc_in),
    .ex_in           (ex_in),
    .ex_code_in      (ex_code_in),
    .dreq_valid      (dreq_valid),
    .dreq_ready      (dreq_ready),
    .dreq_we         (dreq_we),
    .dreq_wstrb      (dreq_wstrb),
    .dreq_addr       (dreq_addr),
    .dreq_wdata      (dreq_wdata),
    .drsp_valid      (drsp_valid),
    .drsp_rdata      (drsp_rdata),
    .pc              (pc),
    .wb_result       (wb_result),
    .rdc_mem         (rdc_mem),
    .rf_we           (rf_we),
    .ex              (ex),
    .ex_code         (ex_code),
    .badvaddr        (badvaddr),
    .fwd_valid       (fwd_valid),
    .fwd_pending     (fwd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic        chk_result;
    logic [4:0]  rdc;
    logic        rf_we;
    logic        ex;
    logic [4:0]  ex_code;
    logic [31:0] badvaddr;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      n_vec = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] res, input logic chk,
                      input logic [4:0] rd, input logic we, input logic e,
                      input logic [4:0] code, input logic [31:0] bva);
    wb_exp_t x;
    x.pc = p; x.result = res; x.chk_result = chk; x.rdc = rd;
    x.rf_we = we; x.ex = e; x.ex_code = code; x.badvaddr = bva;
    sb.push_back(x);
  endtask

  // Compare a WB transfer against the oldest queued expectation.
  task automatic monitor();
    wb_exp_t x;
    if (mem_wb_validto && wb_allowin) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'(mem_wb_validto), 32'd0);
      end else begin
        x = sb.pop_front();
        check("wb_pc", pc, x.pc);
        if (x.chk_result) check("wb_result", wb_result, x.result);
        check("wb_rdc", 32'(rdc_mem), 32'(x.rdc));
        check("wb_rf_we", 32'(rf_we), 32'(x.rf_we));
        check("wb_ex", 32'(ex), 32'(x.ex));
        check("wb_ex_code", 32'(ex_code), 32'(x.ex_code));
        check("wb_badvaddr", badvaddr, x.badvaddr);
      end
    end
  endtask

  task automatic step();
    monitor();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] a, input logic [31:0] r,
                       input logic l, input logic s, input logic [1:0] sz, input logic sx,
                       input logic [1:0] sel, input logic we, input logic [4:0] rd,
                       input logic e, input logic [4:0] ec);
    exe_mem_validto = 1'b1;
    pc_in = p; alu_result_in = a; rt_in = r; ld_in = l; st_in = s;
    size_in = sz; sext_in = sx; rd_mux_sel_in = sel; rf_we_in = we;
    rdc_in = rd; ex_in = e; ex_code_in = ec;
  endtask

  task automatic idle_in();
    exe_mem_validto = 1'b0;
    ld_in = 1'b0; st_in = 1'b0; rf_we_in = 1'b0; ex_in = 1'b0;
  endtask

  logic [31:0] exc_addr[3] = '{32'h0000_3001, 32'h0000_4001, 32'h0000_4002};
  logic        exc_ld[3]   = '{1'b1, 1'b0, 1'b0};
  logic [1:0]  exc_size[3] = '{2'd2, 2'd1, 2'd2};
  logic        exc_up[3]   = '{1'b0, 1'b0, 1'b1};
  logic [4:0]  exc_code[3] = '{5'h04, 5'h05, 5'h0A};

  int pend_cnt;
  int pulse_cnt;

  initial begin
    rst = 1'b1; flush = 1'b0; ex_wb = 1'b0; wb_allowin = 1'b1;
    dreq_ready = 1'b1; drsp_valid = 1'b0; drsp_rdata = '0;
    pc_in = '0; alu_result_in = '0; rt_in = '0;
    hi_in = 32'h0BAD_F00D; lo_in = 32'hDEAD_BEEF;
    size_in = '0; sext_in = 1'b0; rd_mux_sel_in = '0; rdc_in = '0; ex_code_in = '0;
    idle_in();

    // ---- reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rst_mem_wb_validto", 32'(mem_wb_validto), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_fwd_pending", 32'(fwd_pending), 32'd0);
    check("rst_ex", 32'(ex), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_wb_result", wb_result, 32'd0);
    check("rst_mem_allowin", 32'(mem_allowin), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // ---- LB 0x1003, sign-extended, response three cycles after the handshake
    drive(32'h100, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 5'd3, 1'b0, 5'd0);
    push(32'h100, 32'hFFFF_FF80, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0);
    #1; step();
    idle_in();
    pend_cnt = 0; pulse_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drsp_valid = (i == 3);
      drsp_rdata = 32'h80FF_0000;
      #1;
      if (i == 0) begin
        check("lb_dreq_valid", 32'(dreq_valid), 32'd1);
        check("lb_dreq_addr", dreq_addr, 32'h0000_1000);
        check("lb_dreq_wstrb", 32'(dreq_wstrb), 32'h0);
        check("lb_dreq_we", 32'(dreq_we), 32'd0);
      end
      if (i == 1) check("lb_wait_no_req", 32'(dreq_valid), 32'd0);
      if (i == 4) check("lb_fwd_valid", 32'(fwd_valid), 32'd1);
      pend_cnt  += int'(fwd_pending);
      pulse_cnt += int'(mem_wb_validto);
      step();
    end
    drsp_valid = 1'b0;
    check("lb_pending_cycles", 32'(pend_cnt), 32'd4);
    check("lb_wb_pulses", 32'(pulse_cnt), 32'd1);

    // ---- SH 0x2002, request held off one cycle by dreq_ready
    drive(32'h104, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    push(32'h104, 32'h0000_2002, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1; step();
    idle_in();
    dreq_ready = 1'b0;
    #1;
    check("sh_dreq_valid", 32'(dreq_valid), 32'd1);
    check("sh_dreq_wstrb", 32'(dreq_wstrb), 32'hC);
    check("sh_dreq_wdata", dreq_wdata, 32'hABCD_ABCD);
    check("sh_dreq_addr", dreq_addr, 32'h0000_2000);
    check("sh_dreq_we", 32'(dreq_we), 32'd1);
    step();
    dreq_ready = 1'b1;
    #1;
    check("sh_hold_no_wb", 32'(mem_wb_validto), 32'd0);
    step();
    drsp_valid = 1'b1; drsp_rdata = 32'h0;
    #1;
    check("sh_wait_no_wb", 32'(mem_wb_validto), 32'd0);
    check("sh_wait_allowin", 32'(mem_allowin), 32'd0);
    step();
    drsp_valid = 1'b0;
    #1;
    check("sh_done_wb", 32'(mem_wb_validto), 32'd1);
    step();

    // ---- alignment exceptions and upstream exception priority
    for (int i = 0; i < 3; i++) begin
      drive(32'h108 + 32'(4 * i), exc_addr[i], 32'h5555_5555, exc_ld[i], !exc_ld[i],
            exc_size[i], 1'b0, 2'd1, exc_ld[i], 5'd5, exc_up[i], exc_up[i] ? 5'h0A : 5'h00);
      push(32'h108 + 32'(4 * i), 32'd0, 1'b0, 5'd5, 1'b0, 1'b1, exc_code[i], exc_addr[i]);
      #1; step();
      idle_in();
      #1;
      check("exc_no_req", 32'(dreq_valid), 32'd0);
      check("exc_ex", 32'(ex), 32'd1);
      check("exc_code", 32'(ex_code), 32'(exc_code[i]));
      check("exc_badvaddr", badvaddr, exc_addr[i]);
      check("exc_rf_we", 32'(rf_we), 32'd0);
      check("exc_wb_valid", 32'(mem_wb_validto), 32'd1);
      step();
    end

    // ---- flush during WAIT: cancel, drain the late response, never reach WB
    drive(32'h110, 32'h0000_5000, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 1'b1, 5'd6, 1'b0, 5'd0);
    #1; step();
    idle_in();
    pulse_cnt = 0;
    #1;
    check("fl_dreq_valid", 32'(dreq_valid), 32'd1);
    step();
    flush = 1'b1;
    #1;
    pulse_cnt += int'(mem_wb_validto);
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drsp_valid = (i == 2);
      drsp_rdata = 32'h1111_1111;
      #1;
      check("fl_cancel_allowin", 32'(mem_allowin), 32'd0);
      pulse_cnt += int'(mem_wb_validto);
      step();
    end
    drsp_valid = 1'b0;
    #1;
    check("fl_idle_allowin", 32'(mem_allowin), 32'd1);
    check("fl_no_pending", 32'(fwd_pending), 32'd0);
    pulse_cnt += int'(mem_wb_validto);
    check("fl_wb_pulses", 32'(pulse_cnt), 32'd0);
    step();

    // ---- WB stalls while DONE, next instruction waits in EXE
    drive(32'h120, 32'h0000_6004, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd1, 1'b1, 5'd7, 1'b0, 5'd0);
    push(32'h120, 32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
    #1; step();
    idle_in();
    #1; step();
    drsp_valid = 1'b1; drsp_rdata = 32'hCAFE_F00D;
    #1; step();
    drsp_valid = 1'b0; drsp_rdata = 32'h0;
    wb_allowin = 1'b0;
    drive(32'h124, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd3, 1'b1, 5'd8, 1'b0, 5'd0);
    push(32'h124, 32'hDEAD_BEEF, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_allowin", 32'(mem_allowin), 32'd0);
      check("stall_result", wb_result, 32'hCAFE_F00D);
      check("stall_pc", pc, 32'h120);
      check("stall_wb_valid", 32'(mem_wb_validto), 32'd1);
      step();
    end
    wb_allowin = 1'b1;
    #1;
    check("release_allowin", 32'(mem_allowin), 32'd1);
    step();
    idle_in();
    #1;
    check("alu_pc", pc, 32'h124);
    check("alu_lo_result", wb_result, 32'hDEAD_BEEF);
    check("alu_no_req", 32'(dreq_valid), 32'd0);
    check("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    step();

    // ---- reset while a load is waiting
    drive(32'h130, 32'h0000_7000, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 5'd9, 1'b0, 5'd0);
    #1; step();
    idle_in();
    #1; step();
    rst = 1'b1;
    #1; step();
    rst = 1'b0;
    #1;
    check("rw_dreq_valid", 32'(dreq_valid), 32'd0);
    check("rw_mem_wb_validto", 32'(mem_wb_validto), 32'd0);
    check("rw_fwd_pending", 32'(fwd_pending), 32'd0);
    check("rw_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rw_ex", 32'(ex), 32'd0);
    check("rw_rf_we", 32'(rf_we), 32'd0);
    check("rw_pc", pc, 32'd0);
    check("rw_wb_result", wb_result, 32'd0);
    check("rw_mem_allowin", 32'(mem_allowin), 32'd1);
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
